game_flow_controller: RTL and testbench

Top-level game sequencer for Frogger. Replaces the single-bit IDLE/RUNNING flag with a full game-flow FSM covering start handshake, lives, death animation, level-up pause, game over and win. It gates frog control and obstacle motion, and issues the one-cycle strobes that respawn the frog, clear the score and reload the obstacle direction pattern from the LFSR. It sits between the debounced switches, the collision and character-control blocks, and the obstacle, sprite and seven-segment blocks.

---
 rtl/game_flow_controller_pkg.sv | 29 ++
 rtl/game_flow_controller_frame_timer.sv | 39 +++
 rtl/game_flow_controller.sv | 156 +++++++++++++++
 tb/tb_game_flow_controller.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/game_flow_controller_pkg.sv
// Shared types and defaults for the Frogger game-flow sequencer.
package game_flow_controller_pkg;

    // Game-flow states; the encoding is also exported on o_State for debug/display.
    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_START_WAIT  = 3'd1,
        ST_RUNNING     = 3'd2,
        ST_DYING       = 3'd3,
        ST_LEVEL_PAUSE = 3'd4,
        ST_GAME_OVER   = 3'd5,
        ST_WIN         = 3'd6
    } state_t;

    localparam int unsigned C_TIMER_W = 6;

    // Default game constants.
    localparam int C_DEF_LIVES_INI    = 3;
    localparam int C_DEF_SCORE_MAX    = 9;
    localparam int C_DEF_DEATH_FRAMES = 60;
    localparam int C_DEF_LEVEL_FRAMES = 30;
    localparam int C_DEF_OVER_FRAMES  = 60;

    // Lives count down but never wrap below zero.
    function automatic logic [1:0] lives_dec(input logic [1:0] i_Lives);
        return (i_Lives == 2'd0) ? 2'd0 : i_Lives - 2'd1;
    endfunction

endpackage

// File: rtl/game_flow_controller_frame_timer.sv
// frame_timer: 6-bit saturating frame counter with clear and limit detection.
module frame_timer
    import game_flow_controller_pkg::*;
(
    input  logic                 i_Clk,
    input  logic                 i_Reset,
    input  logic                 i_Clear,
    input  logic                 i_Tick,
    input  logic [C_TIMER_W-1:0] i_Limit,
    output logic [C_TIMER_W-1:0] o_Count_Next,
    output logic                 o_Done
);

    logic [C_TIMER_W-1:0] r_Count;
    logic [C_TIMER_W:0]   w_Inc;

    // Next count: clear wins, otherwise increment on tick and hold at all-ones.
    always_comb begin
        w_Inc        = {1'b0, r_Count} + 7'd1;
        o_Count_Next = r_Count;
        if (i_Clear) begin
            o_Count_Next = '0;
        end else if (i_Tick && (r_Count != '1)) begin
            o_Count_Next = w_Inc[C_TIMER_W-1:0];
        end
        // Done on the tick that reaches the limit, or any time after it.
        o_Done = (r_Count >= i_Limit) || (i_Tick && (w_Inc == {1'b0, i_Limit}));
    end

    // Counter register.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_Count <= '0;
        end else begin
            r_Count <= o_Count_Next;
        end
    end

endmodule

// File: rtl/game_flow_controller.sv
// Frogger game-flow FSM: start handshake, lives, death/level pauses, game over and win.
module game_flow_controller
    import game_flow_controller_pkg::*;
#(
    parameter int C_LIVES_INI    = C_DEF_LIVES_INI,
    parameter int C_SCORE_MAX    = C_DEF_SCORE_MAX,
    parameter int C_DEATH_FRAMES = C_DEF_DEATH_FRAMES,
    parameter int C_LEVEL_FRAMES = C_DEF_LEVEL_FRAMES,
    parameter int C_OVER_FRAMES  = C_DEF_OVER_FRAMES
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Frame_Tick,
    input  logic       i_Start,
    input  logic       i_Has_Collided,
    input  logic       i_Level_Up,
    input  logic [3:0] i_Score,
    output logic       o_Game_Active,
    output logic       o_Obstacles_Run,
    output logic       o_Frog_Respawn,
    output logic       o_Score_Clear,
    output logic       o_Reverse_Load,
    output logic       o_Flash,
    output logic [1:0] o_Lives,
    output logic [2:0] o_State
);

    localparam logic [1:0]           C_LIVES_L = 2'(C_LIVES_INI);
    localparam logic [3:0]           C_SMAX_L  = 4'(C_SCORE_MAX);
    localparam logic [C_TIMER_W-1:0] C_DEATH_L = C_TIMER_W'(C_DEATH_FRAMES);
    localparam logic [C_TIMER_W-1:0] C_LEVEL_L = C_TIMER_W'(C_LEVEL_FRAMES);
    localparam logic [C_TIMER_W-1:0] C_OVER_L  = C_TIMER_W'(C_OVER_FRAMES);

    state_t               r_State;
    state_t               w_Next_State;
    logic [1:0]           r_Lives;
    logic [1:0]           w_Lives_Next;
    logic                 w_Respawn;
    logic                 w_Score_Clear;
    logic                 w_Reverse_Load;
    logic                 w_Clear;
    logic                 w_Done;
    logic [C_TIMER_W-1:0] w_Limit;
    logic [C_TIMER_W-1:0] w_Count_Next;

    frame_timer u_frame_timer (
        .i_Clk        (i_Clk),
        .i_Reset      (i_Reset),
        .i_Clear      (w_Clear),
        .i_Tick       (i_Frame_Tick),
        .i_Limit      (w_Limit),
        .o_Count_Next (w_Count_Next),
        .o_Done       (w_Done)
    );

    // Frame limit for the current timed state.
    always_comb begin
        w_Limit = '1;
        case (r_State)
            ST_DYING:       w_Limit = C_DEATH_L;
            ST_LEVEL_PAUSE: w_Limit = C_LEVEL_L;
            ST_GAME_OVER,
            ST_WIN:         w_Limit = C_OVER_L;
            default:        w_Limit = '1;
        endcase
    end

    // Next-state, lives and strobe decode.
    always_comb begin
        w_Next_State   = r_State;
        w_Lives_Next   = r_Lives;
        w_Respawn      = 1'b0;
        w_Score_Clear  = 1'b0;
        w_Reverse_Load = 1'b0;
        case (r_State)
            ST_IDLE: begin
                if (i_Start) begin
                    w_Next_State   = ST_START_WAIT;
                    w_Lives_Next   = C_LIVES_L;
                    w_Respawn      = 1'b1;
                    w_Score_Clear  = 1'b1;
                    w_Reverse_Load = 1'b1;
                end
            end
            ST_START_WAIT: begin
                if (!i_Start) w_Next_State = ST_RUNNING;
            end
            ST_RUNNING: begin
                // Collision has priority; a coincident level-up is dropped.
                if (i_Has_Collided) begin
                    w_Next_State = ST_DYING;
                    w_Lives_Next = lives_dec(r_Lives);
                end else if (i_Level_Up) begin
                    w_Next_State   = ST_LEVEL_PAUSE;
                    w_Reverse_Load = 1'b1;
                end
            end
            ST_DYING: begin
                if (w_Done) begin
                    if (r_Lives == 2'd0) begin
                        w_Next_State = ST_GAME_OVER;
                    end else begin
                        w_Next_State = ST_RUNNING;
                        w_Respawn    = 1'b1;
                    end
                end
            end
            ST_LEVEL_PAUSE: begin
                if (w_Done) begin
                    if (i_Score >= C_SMAX_L) begin
                        w_Next_State = ST_WIN;
                    end else begin
                        w_Next_State = ST_RUNNING;
                        w_Respawn    = 1'b1;
                    end
                end
            end
            ST_GAME_OVER,
            ST_WIN: begin
                if (w_Done && !i_Start) w_Next_State = ST_IDLE;
            end
            default: w_Next_State = ST_IDLE;
        endcase
        w_Clear = (w_Next_State != r_State);
    end

    // Registered state and outputs; enables are decoded from the next state so
    // they change in the same cycle as o_State.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_State         <= ST_IDLE;
            r_Lives         <= C_LIVES_L;
            o_Game_Active   <= 1'b0;
            o_Obstacles_Run <= 1'b0;
            o_Frog_Respawn  <= 1'b0;
            o_Score_Clear   <= 1'b0;
            o_Reverse_Load  <= 1'b0;
            o_Flash         <= 1'b0;
        end else begin
            r_State         <= w_Next_State;
            r_Lives         <= w_Lives_Next;
            o_Game_Active   <= (w_Next_State == ST_RUNNING);
            o_Obstacles_Run <= (w_Next_State == ST_START_WAIT) ||
                               (w_Next_State == ST_RUNNING) ||
                               (w_Next_State == ST_LEVEL_PAUSE);
            o_Frog_Respawn  <= w_Respawn;
            o_Score_Clear   <= w_Score_Clear;
            o_Reverse_Load  <= w_Reverse_Load;
            o_Flash         <= (w_Next_State == ST_DYING) && w_Count_Next[2];
        end
    end

    assign o_Lives = r_Lives;
    assign o_State = r_State;

endmodule

// File: tb/tb_game_flow_controller.sv
// Self-checking bench for game_flow_controller against a behavioural game model.
module tb_game_flow_controller;

    localparam int S_IDLE = 0, S_SWAIT = 1, S_RUN = 2, S_DYING = 3,
                   S_LEVEL = 4, S_OVER = 5, S_WIN = 6;

    logic       clk = 1'b0;
    logic       i_Reset = 1'b1, i_Frame_Tick = 1'b0, i_Start = 1'b0;
    logic       i_Has_Collided = 1'b0, i_Level_Up = 1'b0;
    logic [3:0] i_Score = '0;
    logic       o_Game_Active, o_Obstacles_Run, o_Frog_Respawn, o_Score_Clear;
    logic       o_Reverse_Load, o_Flash;
    logic [1:0] o_Lives;
    logic [2:0] o_State;

    int tests = 0;
    int fails = 0;

    // Reference model of the game rules.
    int m_state = S_IDLE, m_cnt = 0, m_lives = 3;
    int m_respawn = 0, m_clear = 0, m_rev = 0;

    always #5 clk = ~clk;

    game_flow_controller #(
        .C_LIVES_INI(3), .C_SCORE_MAX(9), .C_DEATH_FRAMES(60),
        .C_LEVEL_FRAMES(30), .C_OVER_FRAMES(60)
    ) dut (
        .i_Clk(clk), .i_Reset(i_Reset), .i_Frame_Tick(i_Frame_Tick),
        .i_Start(i_Start), .i_Has_Collided(i_Has_Collided), .i_Level_Up(i_Level_Up),
        .i_Score(i_Score), .o_Game_Active(o_Game_Active), .o_Obstacles_Run(o_Obstacles_Run),
        .o_Frog_Respawn(o_Frog_Respawn), .o_Score_Clear(o_Score_Clear),
        .o_Reverse_Load(o_Reverse_Load), .o_Flash(o_Flash), .o_Lives(o_Lives), .o_State(o_State)
    );

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int limit_of(input int s);
        if (s == S_DYING) return 60;
        if (s == S_LEVEL) return 30;
        return 60;
    endfunction

    // Advance the model by one clock using the inputs just applied.
    task automatic model_step(input logic rst, st, col, lvl, tick, input int sc);
        int nxt, newcnt;
        m_respawn = 0; m_clear = 0; m_rev = 0;
        if (rst) begin
            m_state = S_IDLE; m_cnt = 0; m_lives = 3;
            return;
        end
        nxt = m_state;
        newcnt = tick ? ((m_cnt < 63) ? m_cnt + 1 : 63) : m_cnt;
        case (m_state)
            S_IDLE:  if (st) begin nxt = S_SWAIT; m_lives = 3; m_respawn = 1; m_clear = 1; m_rev = 1; end
            S_SWAIT: if (!st) nxt = S_RUN;
            S_RUN: begin
                if (col) begin nxt = S_DYING; m_lives = (m_lives > 0) ? m_lives - 1 : 0; end
                else if (lvl) begin nxt = S_LEVEL; m_rev = 1; end
            end
            S_DYING: if (newcnt >= limit_of(S_DYING)) begin
                if (m_lives == 0) nxt = S_OVER; else begin nxt = S_RUN; m_respawn = 1; end
            end
            S_LEVEL: if (newcnt >= limit_of(S_LEVEL)) begin
                if (sc >= 9) nxt = S_WIN; else begin nxt = S_RUN; m_respawn = 1; end
            end
            default: if (newcnt >= limit_of(m_state) && !st) nxt = S_IDLE;
        endcase
        m_cnt = (nxt != m_state) ? 0 : newcnt;
        m_state = nxt;
    endtask

    // Apply one cycle of inputs (random frame tick), then compare all outputs.
    task automatic step(input logic rst, st, col, lvl, input int sc);
        logic tick;
        tick = ($urandom_range(0, 2) == 0);
        i_Reset = rst; i_Start = st; i_Has_Collided = col; i_Level_Up = lvl;
        i_Score = 4'(sc); i_Frame_Tick = tick;
        @(posedge clk);
        model_step(rst, st, col, lvl, tick, sc);
        #1;
        check("state",   int'(o_State),         m_state);
        check("lives",   int'(o_Lives),         m_lives);
        check("active",  int'(o_Game_Active),   int'(m_state == S_RUN));
        check("obst",    int'(o_Obstacles_Run), int'(m_state == S_SWAIT || m_state == S_RUN || m_state == S_LEVEL));
        check("flash",   int'(o_Flash),         int'(m_state == S_DYING && ((m_cnt >> 2) & 1) == 1));
        check("respawn", int'(o_Frog_Respawn),  m_respawn);
        check("sclear",  int'(o_Score_Clear),   m_clear);
        check("revload", int'(o_Reverse_Load),  m_rev);
    endtask

    task automatic wait_state(input string tag, input int target, input int sc, input int bound);
        int n = 0;
        while (int'(o_State) != target && n < bound) begin
            step(0, 0, 0, 0, sc);
            n++;
        end
        check(tag, int'(o_State), target);
    endtask

    task automatic start_game();
        repeat (3) step(0, 1, 0, 0, 0);
        check("start_state", int'(o_State), S_SWAIT);
        check("start_lives", int'(o_Lives), 3);
        check("start_frozen", int'(o_Game_Active), 0);
        step(0, 0, 0, 0, 0);
        check("run_after_release", int'(o_State), S_RUN);
    endtask

    initial begin
        // Reset state
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("rst_state", int'(o_State), S_IDLE);
        check("rst_lives", int'(o_Lives), 3);

        // Start handshake and one death/respawn
        start_game();
        repeat (4) step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        check("die_state", int'(o_State), S_DYING);
        check("die_lives", int'(o_Lives), 2);
        wait_state("respawn_run", S_RUN, 0, 1000);

        // Remaining two lives lead to game over, then back to idle
        step(0, 0, 1, 0, 0);
        wait_state("respawn_run2", S_RUN, 0, 1000);
        step(0, 0, 1, 0, 0);
        wait_state("game_over", S_OVER, 0, 1000);
        check("over_lives", int'(o_Lives), 0);
        wait_state("over_idle", S_IDLE, 0, 1000);

        // Level up with score 5, then win with score 9
        start_game();
        step(0, 0, 0, 1, 5);
        check("lvl_state", int'(o_State), S_LEVEL);
        wait_state("lvl_run", S_RUN, 5, 1000);
        step(0, 0, 0, 1, 9);
        wait_state("win", S_WIN, 9, 1000);
        wait_state("win_idle", S_IDLE, 9, 1000);

        // Simultaneous collision and level-up
        start_game();
        step(0, 0, 1, 1, 9);
        check("both_state", int'(o_State), S_DYING);
        check("both_lives", int'(o_Lives), 2);
        check("both_norev", int'(o_Reverse_Load), 0);

        // Reset during DYING, then during LEVEL_PAUSE
        repeat (5) step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("rst_dying_state", int'(o_State), S_IDLE);
        check("rst_dying_lives", int'(o_Lives), 3);
        start_game();
        step(0, 0, 0, 1, 3);
        repeat (5) step(0, 0, 0, 0, 3);
        step(1, 1, 1, 1, 3);
        check("rst_lvl_state", int'(o_State), S_IDLE);
        check("rst_lvl_obst", int'(o_Obstacles_Run), 0);

        // Start held through reset release
        step(0, 1, 0, 0, 0);
        check("start_thru_rst", int'(o_State), S_SWAIT);

        // Randomized play
        for (int i = 0; i < 6000; i++) begin
            step(($urandom_range(0, 499) == 0),
                 ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 29) == 0),
                 int'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
